// File: rtl/a1csa_spec_adder_pkg.sv
// Shared definitions for the a1csa speculative carry-select adder.
//   - a1csa_state_e : 2-bit FSM state encoding (IDLE, SPEC, RECOVER, DONE)
//   - A1CSA_N_DEF / A1CSA_K_DEF : default operand width and block width
//   - A1CSA_CNT_W : width of the optional recovery counter
package a1csa_spec_adder_pkg;

    localparam int unsigned A1CSA_N_DEF = 16;
    localparam int unsigned A1CSA_K_DEF = 4;
    localparam int unsigned A1CSA_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SPEC    = 2'd1,
        ST_RECOVER = 2'd2,
        ST_DONE    = 2'd3
    } a1csa_state_e;

endpackage

// File: rtl/a1csa_spec_adder_blk_spec.sv
// One K-bit carry-select block.
// Ports:
//   a_i, b_i  : K-bit operand slices
//   cin_i     : carry-in used for the block sum (speculative carry)
//   g_o       : block generate, carry-out of a_i+b_i with carry-in 0
//   p_o       : block propagate, all bit positions propagate
//   sum_o     : a_i + b_i + cin_i, K bits
module a1csa_blk_spec #(
    parameter int unsigned K = 4
) (
    input  logic [K-1:0] a_i,
    input  logic [K-1:0] b_i,
    input  logic         cin_i,
    output logic         g_o,
    output logic         p_o,
    output logic [K-1:0] sum_o
);

    logic [K:0] raw_sum;

    assign raw_sum = {1'b0, a_i} + {1'b0, b_i};
    assign g_o     = raw_sum[K];
    assign p_o     = &(a_i ^ b_i);
    assign sum_o   = a_i + b_i + K'(cin_i);

endmodule

// File: rtl/a1csa_spec_adder.sv
// Variable-latency approximate carry-select adder.
// Each block speculates its carry-in from the previous block's generate only;
// blocks whose speculative carry-in was wrong are incremented in one extra
// RECOVER cycle. Result is always the exact a+b.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b                 : N-bit operands
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, cout            : exact sum mod 2^N and carry-out
//   spec_err             : 1 when the recovery cycle was used
//   err_count            : saturating recovery counter, only with A1CSA_ERR_COUNT_EN
// Optional feature macro: A1CSA_ERR_COUNT_EN
module a1csa_spec_adder
    import a1csa_spec_adder_pkg::*;
#(
    parameter int unsigned N = A1CSA_N_DEF,
    parameter int unsigned K = A1CSA_K_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         spec_err
`ifdef A1CSA_ERR_COUNT_EN
    ,
    output logic [A1CSA_CNT_W-1:0] err_count
`endif
);

    localparam int unsigned NB = N / K;

    if ((N % K) != 0) begin : g_bad_width
        $error("a1csa_spec_adder: N must be a multiple of K");
    end

    a1csa_state_e state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          err_q, err_d;
    logic [NB-1:0] fix_q, fix_d;

    logic [NB-1:0] blk_g, blk_p, spec_cin, true_cin, fix;
    logic [N-1:0]  spec_sum, rec_sum;
    logic          exact_cout;

    for (genvar j = 0; j < NB; j++) begin : g_blk
        if (j == 0) begin : g_first
            assign spec_cin[j] = 1'b0;
        end else begin : g_rest
            assign spec_cin[j] = blk_g[j-1];
        end

        a1csa_blk_spec #(.K(K)) u_blk (
            .a_i   (a_q[j*K +: K]),
            .b_i   (b_q[j*K +: K]),
            .cin_i (spec_cin[j]),
            .g_o   (blk_g[j]),
            .p_o   (blk_p[j]),
            .sum_o (spec_sum[j*K +: K])
        );
    end

    // Exact carry chain at block granularity, used only to detect
    // mis-speculated blocks and the final carry-out.
    always_comb begin
        logic c;
        true_cin = '0;
        c        = 1'b0;
        for (int j = 0; j < int'(NB); j++) begin
            true_cin[j] = c;
            c = blk_g[j] | (blk_p[j] & c);
        end
        exact_cout = c;
    end

    // Speculative carry can only be too small, so a wrong block is fixed by +1.
    assign fix = true_cin & ~spec_cin;

    // Increment flagged blocks: a bit toggles when all lower bits of its block are 1.
    always_comb begin
        logic c;
        rec_sum = sum_q;
        for (int j = 0; j < int'(NB); j++) begin
            c = fix_q[j];
            for (int i = 0; i < int'(K); i++) begin
                rec_sum[j*K+i] = sum_q[j*K+i] ^ c;
                c = c & sum_q[j*K+i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        fix_d   = fix_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = ST_SPEC;
                end
            end
            ST_SPEC: begin
                sum_d   = spec_sum;
                fix_d   = fix;
                cout_d  = exact_cout;
                err_d   = 1'b0;
                state_d = (|fix) ? ST_RECOVER : ST_DONE;
            end
            ST_RECOVER: begin
                sum_d   = rec_sum;
                err_d   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            fix_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            fix_q   <= fix_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign spec_err  = err_q;

`ifdef A1CSA_ERR_COUNT_EN
    logic [A1CSA_CNT_W-1:0] cnt_q, cnt_d;

    // RECOVER always moves to DONE, so being in RECOVER marks that transition.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_RECOVER && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`endif

endmodule
